// File: rtl/axil_responder_pkg.sv
// Shared definitions for the AXI4-Lite register responder.
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   INDEX_WIDTH             : width of a register index (covers up to 256 registers)
//   wr_state_t / rd_state_t : write and read channel FSM states
//   register_index()        : word index of an address relative to a base address
package axil_responder_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int INDEX_WIDTH = 8;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_HAVE_ADDR,
        WR_HAVE_DATA,
        WR_COMMIT,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    // Only the low index bits matter. They are identical whether the
    // subtraction is done at 64 bits or at the bus address width.
    function automatic logic [INDEX_WIDTH-1:0] register_index(input logic [63:0] addr,
                                                               input logic [63:0] base);
        return INDEX_WIDTH'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/axil_address_decoder.sv
// Combinational address decoder for one register window.
//   addr  in  ADDR_WIDTH   byte address to decode
//   index out INDEX_WIDTH  word index of addr within the window
//   hit   out 1            addr is word aligned and inside [BASE, BASE + 4*N_REGISTERS)
// An address below the base wraps to a large offset and therefore misses.
module axil_address_decoder
    import axil_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = 32'h43c01000,
    parameter int                    N_REGISTERS  = 8
) (
    input  logic [ADDR_WIDTH-1:0]  addr,
    output logic [INDEX_WIDTH-1:0] index,
    output logic                   hit
);

    // One extra bit so the window span can never be truncated.
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(4 * N_REGISTERS);

    logic [ADDR_WIDTH-1:0] offset;

    always_comb begin
        offset = addr - BASE_ADDRESS;
        hit    = ({1'b0, offset} < SPAN) && (addr[1:0] == 2'b00);
        index  = register_index(64'(addr), 64'(BASE_ADDRESS));
    end

endmodule

// File: rtl/axil_register_responder.sv
// AXI4-Lite responder holding N_REGISTERS 32-bit control registers.
//   clock, reset            : single rising-edge clock, synchronous active-high reset
//   s_aw*, s_w*, s_b*       : write address / data / response channels
//   s_ar*, s_r*             : read address / data channels
//   registers_out           : register file, register i at [32*i +: 32]
//   write_strobe            : one-cycle pulse when a write to register i commits
//   wr_state_dbg/rd_state_dbg : current write / read FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the source holds valid and payload stable until that edge, and a
// response (bvalid/rvalid) stays asserted with a stable payload until accepted.
module axil_register_responder
    import axil_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = 32'h43c01000,
    parameter int                    N_REGISTERS  = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [31:0]               s_wdata,
    input  logic [3:0]                s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    input  logic [ADDR_WIDTH-1:0]     s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [31:0]               s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [32*N_REGISTERS-1:0] registers_out,
    output logic [N_REGISTERS-1:0]    write_strobe,
    output wr_state_t                 wr_state_dbg,
    output rd_state_t                 rd_state_dbg
);

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic [N_REGISTERS-1:0][31:0] regs;
    logic [ADDR_WIDTH-1:0]        awaddr_q;
    logic [31:0]                  wdata_q;
    logic [3:0]                   wstrb_q;

    logic [INDEX_WIDTH-1:0] aw_index, ar_index;
    logic                   aw_hit, ar_hit;
    logic                   aw_hs, w_hs, ar_hs;
    logic [31:0]            rd_word;

    // The write decoder looks at the latched address, which is stable by COMMIT.
    axil_address_decoder #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BASE_ADDRESS(BASE_ADDRESS),
        .N_REGISTERS (N_REGISTERS)
    ) u_aw_decoder (
        .addr (awaddr_q),
        .index(aw_index),
        .hit  (aw_hit)
    );

    axil_address_decoder #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BASE_ADDRESS(BASE_ADDRESS),
        .N_REGISTERS (N_REGISTERS)
    ) u_ar_decoder (
        .addr (s_araddr),
        .index(ar_index),
        .hit  (ar_hit)
    );

    // Each ready drops once its half of the write is latched and stays low
    // until the response has been accepted.
    assign s_awready = (wr_state == WR_IDLE) || (wr_state == WR_HAVE_DATA);
    assign s_wready  = (wr_state == WR_IDLE) || (wr_state == WR_HAVE_ADDR);
    assign s_arready = (rd_state == RD_IDLE);

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign ar_hs = s_arvalid && s_arready;

    assign registers_out = regs;
    assign wr_state_dbg  = wr_state;
    assign rd_state_dbg  = rd_state;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs && w_hs) wr_next = WR_COMMIT;
                else if (aw_hs)    wr_next = WR_HAVE_ADDR;
                else if (w_hs)     wr_next = WR_HAVE_DATA;
            end
            WR_HAVE_ADDR: if (w_hs)     wr_next = WR_COMMIT;
            WR_HAVE_DATA: if (aw_hs)    wr_next = WR_COMMIT;
            WR_COMMIT:                  wr_next = WR_RESP;
            WR_RESP:      if (s_bready) wr_next = WR_IDLE;
            default:                    wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs)    rd_next = RD_RESP;
            RD_RESP: if (s_rready) rd_next = RD_IDLE;
            default:               rd_next = RD_IDLE;
        endcase
    end

    // Read mux over the current (pre-commit) register contents.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_REGISTERS; i++) begin
            if (ar_index == INDEX_WIDTH'(i)) rd_word = regs[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regs         <= '0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            write_strobe <= '0;
            s_bvalid     <= 1'b0;
            s_bresp      <= RESP_OKAY;
        end else begin
            write_strobe <= '0;
            if (aw_hs) awaddr_q <= s_awaddr;
            if (w_hs) begin
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
            end
            if (wr_state == WR_COMMIT) begin
                s_bvalid <= 1'b1;
                s_bresp  <= aw_hit ? RESP_OKAY : RESP_SLVERR;
                if (aw_hit) begin
                    for (int i = 0; i < N_REGISTERS; i++) begin
                        if (aw_index == INDEX_WIDTH'(i)) begin
                            write_strobe[i] <= 1'b1;
                            for (int b = 0; b < 4; b++) begin
                                if (wstrb_q[b]) regs[i][8*b +: 8] <= wdata_q[8*b +: 8];
                            end
                        end
                    end
                end
            end else if (wr_state == WR_RESP && s_bready) begin
                s_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            s_rvalid <= 1'b1;
            s_rdata  <= ar_hit ? rd_word : 32'h0;
            s_rresp  <= ar_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (rd_state == RD_RESP && s_rready) begin
            s_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_register_responder.sv
module tb_axil_register_responder;
  import axil_responder_pkg::*;

  localparam int          N    = 8;
  localparam logic [31:0] BASE = 32'h43c01000;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [31:0]    s_awaddr = '0;
  logic           s_awvalid = 1'b0;
  logic           s_awready;
  logic [31:0]    s_wdata = '0;
  logic [3:0]     s_wstrb = '0;
  logic           s_wvalid = 1'b0;
  logic           s_wready;
  logic [1:0]     s_bresp;
  logic           s_bvalid;
  logic           s_bready = 1'b0;
  logic [31:0]    s_araddr = '0;
  logic           s_arvalid = 1'b0;
  logic           s_arready;
  logic [31:0]    s_rdata;
  logic [1:0]     s_rresp;
  logic           s_rvalid;
  logic           s_rready = 1'b0;
  logic [32*N-1:0] registers_out;
  logic [N-1:0]   write_strobe;
  wr_state_t      wr_state_dbg;
  rd_state_t      rd_state_dbg;

  axil_register_responder #(
    .ADDR_WIDTH(32),
    .BASE_ADDRESS(BASE),
    .N_REGISTERS(N)
  ) dut (
    .clock(clock), .reset(reset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .registers_out(registers_out), .write_strobe(write_strobe),
    .wr_state_dbg(wr_state_dbg), .rd_state_dbg(rd_state_dbg)
  );

  // ---------------- model / scoreboard ----------------
  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  logic [31:0] model_regs [N];
  logic [N-1:0] exp_strobe = '0;
  logic        exp_bvalid = 1'b0;
  logic [1:0]  exp_bresp = 2'b00;
  logic        exp_rvalid = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic [1:0]  exp_rresp = 2'b00;

  task automatic check(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    longint unsigned ua;
    longint unsigned ub;
    ua = longint'(a);
    ub = longint'(BASE);
    return (ua >= ub) && (ua < ub + 4 * N) && (a % 4 == 0);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [32*N-1:0] model_pack();
    logic [32*N-1:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = model_regs[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) model_regs[i] = '0;
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clock) begin
    if (cmp_en && !reset) begin
      check("registers_out", registers_out, model_pack());
      check("write_strobe", write_strobe, exp_strobe);
      check("bvalid", s_bvalid, exp_bvalid);
      if (exp_bvalid) check("bresp", s_bresp, exp_bresp);
      check("rvalid", s_rvalid, exp_rvalid);
      if (exp_rvalid) begin
        check("rdata", s_rdata, exp_rdata);
        check("rresp", s_rresp, exp_rresp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 1'b0;
    bit w_done = 1'b0;
    bit aw_hs;
    bit w_hs;
    bit hit;
    int idx;
    int t = 0;
    while (!(aw_done && w_done)) begin
      if (!aw_done && t >= aw_dly) begin s_awvalid = 1'b1; s_awaddr = addr; end
      if (!w_done && t >= w_dly) begin s_wvalid = 1'b1; s_wdata = data; s_wstrb = strb; end
      @(negedge clock);
      check("awready_open", s_awready, !aw_done);
      check("wready_open", s_wready, !w_done);
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      @(posedge clock); #1;
      if (aw_hs) begin aw_done = 1'b1; s_awvalid = 1'b0; end
      if (w_hs) begin w_done = 1'b1; s_wvalid = 1'b0; end
      t++;
      if (t > 20) begin
        check("wr_handshake_timeout", 1'b1, 1'b0);
        s_awvalid = 1'b0;
        s_wvalid = 1'b0;
        return;
      end
    end
    // Commit cycle; the response and register update appear after the next edge.
    @(posedge clock); #1;
    hit = model_hit(addr);
    idx = hit ? model_idx(addr) : 0;
    if (hit) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
      exp_strobe = N'(1) << idx;
    end else begin
      exp_strobe = '0;
    end
    exp_bvalid = 1'b1;
    exp_bresp  = hit ? 2'b00 : 2'b10;
    for (int k = 0; k <= b_dly; k++) begin
      s_bready = (k == b_dly);
      @(negedge clock);
      check("awready_resp", s_awready, 1'b0);
      check("wready_resp", s_wready, 1'b0);
      @(posedge clock); #1;
      exp_strobe = '0;
    end
    s_bready = 1'b0;
    exp_bvalid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int pre, input int r_dly,
                         output logic [31:0] got);
    logic [31:0] d;
    logic [1:0]  r;
    got = '0;
    repeat (pre) begin @(posedge clock); #1; end
    s_arvalid = 1'b1;
    s_araddr  = addr;
    @(negedge clock);
    check("arready_idle", s_arready, 1'b1);
    // Value captured at the handshake edge: whatever the model holds before it.
    d = model_hit(addr) ? model_regs[model_idx(addr)] : 32'h0;
    r = model_hit(addr) ? 2'b00 : 2'b10;
    @(posedge clock); #1;
    s_arvalid  = 1'b0;
    exp_rvalid = 1'b1;
    exp_rdata  = d;
    exp_rresp  = r;
    for (int k = 0; k <= r_dly; k++) begin
      s_rready = (k == r_dly);
      @(negedge clock);
      if (k == 0) got = s_rdata;
      check("arready_busy", s_arready, 1'b0);
      @(posedge clock); #1;
    end
    s_rready = 1'b0;
    exp_rvalid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] got;
    model_clear();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    check("rst_awready", s_awready, 1'b1);
    check("rst_wready", s_wready, 1'b1);
    check("rst_arready", s_arready, 1'b1);
    check("rst_bvalid", s_bvalid, 1'b0);
    check("rst_rvalid", s_rvalid, 1'b0);
    check("rst_bresp", s_bresp, 2'b00);
    check("rst_rresp", s_rresp, 2'b00);
    check("rst_rdata", s_rdata, 32'h0);
    check("rst_strobe", write_strobe, '0);
    check("rst_regs", registers_out, '0);
    cmp_en = 1'b1;
    @(posedge clock); #1;

    // 1: AW and W together, full strobe
    do_write(32'h43c01008, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check("t1_reg2_literal", registers_out[95:64], 32'hDEADBEEF);

    // 2: W first, AW three cycles later, partial strobe, slow bready
    do_write(32'h43c01000, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(32'h43c01000, 32'h12345678, 4'h3, 3, 0, 4);
    check("t2_reg0_literal", registers_out[31:0], 32'hFFFF5678);

    // 3: out-of-range and misaligned writes
    do_write(32'h43c01020, 32'h11111111, 4'hF, 0, 0, 0);
    do_write(32'h43c01002, 32'h22222222, 4'hF, 0, 1, 0);
    check("t3_regs_literal", registers_out[95:0], {32'hDEADBEEF, 32'h0, 32'hFFFF5678});

    // Boundary: last register, and an all-zero strobe on a hit
    do_write(32'h43c0101c, 32'h0BADF00D, 4'hF, 2, 0, 1);
    check("last_reg_literal", registers_out[255:224], 32'h0BADF00D);
    do_write(32'h43c0100c, 32'hCAFEF00D, 4'h0, 0, 0, 0);
    check("zero_strb_literal", registers_out[127:96], 32'h0);

    // 4: reads below base, past end, and with rready held low
    do_read(32'h43c00ffc, 0, 0, got);
    check("t4_below_base_rdata", got, 32'h0);
    do_read(32'h43c01020, 0, 1, got);
    check("past_end_rdata", got, 32'h0);
    do_read(32'h43c01008, 0, 3, got);
    check("t4_reg2_literal", got, 32'hDEADBEEF);

    // 5: read captured in the commit cycle of a write to the same register
    fork
      do_write(32'h43c01004, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
      begin
        logic [31:0] g5;
        do_read(32'h43c01004, 1, 0, g5);
        check("t5_pre_write_literal", g5, 32'h0);
      end
    join
    do_read(32'h43c01004, 0, 0, got);
    check("t5_post_write_literal", got, 32'hA5A5A5A5);

    // 6: reset with a latched write address and a pending read response
    s_awvalid = 1'b1; s_awaddr = 32'h43c01004;
    s_arvalid = 1'b1; s_araddr = 32'h43c01008;
    @(negedge clock);
    @(posedge clock); #1;
    s_awvalid = 1'b0;
    s_arvalid = 1'b0;
    exp_rvalid = 1'b1;
    exp_rdata  = 32'hDEADBEEF;
    exp_rresp  = 2'b00;
    @(negedge clock);
    check("t6_wr_have_addr", wr_state_dbg, WR_HAVE_ADDR);
    check("t6_rd_resp", rd_state_dbg, RD_RESP);
    check("t6_awready_low", s_awready, 1'b0);
    check("t6_arready_low", s_arready, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
    exp_rvalid = 1'b0;
    exp_bvalid = 1'b0;
    exp_strobe = '0;
    @(negedge clock);
    check("t6_awready", s_awready, 1'b1);
    check("t6_wready", s_wready, 1'b1);
    check("t6_arready", s_arready, 1'b1);
    check("t6_regs_zero", registers_out, '0);
    @(posedge clock); #1;
    do_write(32'h43c01004, 32'h0000BEEF, 4'hF, 1, 0, 1);
    do_read(32'h43c01004, 0, 0, got);
    check("t6_fresh_write_literal", got, 32'h0000BEEF);

    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
